// File: rtl/wave_channel_param_if.sv
// Wave channel register-side bundle: decoded NR30-NR34 / wave RAM controls
// in, playback status and sample out.
interface wave_channel_param_if #(
  parameter int SAMPLE_W = 4,
  parameter int ADDR_W   = 5,
  parameter int FREQ_W   = 11,
  parameter int LEN_W    = 8
);
  logic                tick_len;
  logic                dac_en;
  logic [1:0]          vol;
  logic [LEN_W-1:0]    len_load;
  logic                len_wr;
  logic                len_en;
  logic                trigger;
  logic [FREQ_W-1:0]   freq;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [SAMPLE_W-1:0] wr_data;
  logic [SAMPLE_W-1:0] signal;
  logic                active;
  logic [ADDR_W-1:0]   pos;

  modport master (
    output tick_len, dac_en, vol, len_load, len_wr, len_en, trigger, freq,
           wr_en, wr_addr, wr_data,
    input  signal, active, pos
  );

  modport slave (
    input  tick_len, dac_en, vol, len_load, len_wr, len_en, trigger, freq,
           wr_en, wr_addr, wr_data,
    output signal, active, pos
  );
endinterface

// File: rtl/wave_channel_param.sv
// Parametrised wave playback channel: private wave RAM stepped at a
// programmable period, length counter, volume shifter, registered output.
module wave_channel_param #(
  parameter int SAMPLE_W = 4,
  parameter int ADDR_W   = 5,
  parameter int FREQ_W   = 11,
  parameter int LEN_W    = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  wave_channel_param_if.slave bus
);

  localparam int TMR_W = FREQ_W + 2;
  localparam logic [FREQ_W:0] FULL_FREQ = (FREQ_W+1)'(1) << FREQ_W;
  localparam logic [LEN_W:0]  FULL_LEN  = (LEN_W+1)'(1) << LEN_W;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state;
  logic [SAMPLE_W-1:0] ram [0:2**ADDR_W-1];
  logic [SAMPLE_W-1:0] sample_buf;
  logic [ADDR_W-1:0]   pos_q;
  logic [LEN_W:0]      len_cnt;
  logic [TMR_W-1:0]    timer;

  logic [TMR_W-1:0]    period;
  logic [ADDR_W-1:0]   pos_nxt;
  logic [SAMPLE_W-1:0] rd_nxt;
  logic [LEN_W:0]      len_loaded;
  logic [LEN_W:0]      len_base;
  logic [LEN_W:0]      len_trig;
  logic                active;
  logic                start;
  logic                step;
  logic                len_tick;
  logic                len_hit_zero;

  assign active     = (state == PLAY);
  assign bus.active = active;
  assign bus.pos    = pos_q;

  // Next-state helpers: period, step read with write-through, length values
  always_comb begin
    period       = {FULL_FREQ - {1'b0, bus.freq}, 1'b0};
    pos_nxt      = pos_q + ADDR_W'(1);
    rd_nxt       = (bus.wr_en && bus.wr_addr == pos_nxt) ? bus.wr_data : ram[pos_nxt];
    len_loaded   = FULL_LEN - {1'b0, bus.len_load};
    // a len_wr in the trigger cycle is seen by the trigger's zero check
    len_base     = bus.len_wr ? len_loaded : len_cnt;
    len_trig     = (len_base == '0) ? FULL_LEN : len_base;
    start        = bus.trigger & bus.dac_en;
    step         = active & bus.dac_en & ~start & (timer <= TMR_W'(1));
    len_tick     = ~start & ~bus.len_wr & bus.tick_len & bus.len_en & (len_cnt != '0);
    len_hit_zero = len_tick & (len_cnt == (LEN_W+1)'(1));
  end

  // Playback FSM with timer, position, sample buffer and length counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pos_q      <= '0;
      sample_buf <= '0;
      len_cnt    <= '0;
      timer      <= '0;
    end else if (start) begin
      state   <= PLAY;
      pos_q   <= '0;
      timer   <= period;
      len_cnt <= len_trig;
    end else begin
      if (bus.len_wr) begin
        len_cnt <= len_loaded;
      end else if (len_tick) begin
        len_cnt <= len_cnt - (LEN_W+1)'(1);
      end
      if (state == PLAY) begin
        if (!bus.dac_en || len_hit_zero) begin
          state <= IDLE;
        end
        if (bus.dac_en) begin
          if (step) begin
            pos_q      <= pos_nxt;
            sample_buf <= rd_nxt;
            timer      <= period;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
      end
    end
  end

  // Registered volume-shifted output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.signal <= '0;
    end else if (active && bus.dac_en && bus.vol != 2'd0) begin
      bus.signal <= sample_buf >> (bus.vol - 2'd1);
    end else begin
      bus.signal <= '0;
    end
  end

  // Wave RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      ram[bus.wr_addr] <= bus.wr_data;
    end
  end

endmodule
